// File: rtl/tt_um_hamming_encoder_7_4.sv
// Serial Hamming(7,4) encoder: a one-entry nibble buffer feeds an MSB-first codeword shifter.
// Optional macro HAMMING_PARITY_EXT_EN appends an overall even-parity bit p0 (8-bit frames).
module tt_um_hamming_encoder_7_4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       encode_out,
  output logic       bit_valid,
  output logic       frame_start,
  output logic       busy
);

`ifdef HAMMING_PARITY_EXT_EN
  localparam int FRAME_W = 8;
`else
  localparam int FRAME_W = 7;
`endif
  localparam logic [2:0] LAST_BIT = 3'(FRAME_W - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_reg;
  logic [2:0]         count_reg;
  logic [FRAME_W-1:0] shift_reg;
  logic [3:0]         hold_reg;
  logic               hold_full_reg;
  logic               data_ready_reg;

  logic accept;
  logic last_bit;
  logic load;
  logic hold_full_next;

  // Frame layout, first-sent bit in the MSB: p1 p2 d1 p3 d2 d3 d4 [p0]
  function automatic logic [FRAME_W-1:0] hamming_encode(input logic [3:0] nib);
    logic d1, d2, d3, d4;
    logic [6:0] cw;
    d1 = nib[3];
    d2 = nib[2];
    d3 = nib[1];
    d4 = nib[0];
    cw = {d1 ^ d2 ^ d4, d1 ^ d3 ^ d4, d1, d2 ^ d3 ^ d4, d2, d3, d4};
`ifdef HAMMING_PARITY_EXT_EN
    return {cw, ^cw};
`else
    return cw;
`endif
  endfunction

  always_comb begin
    accept         = 1'b0;
    last_bit       = 1'b0;
    load           = 1'b0;
    hold_full_next = 1'b0;
    accept   = data_valid & data_ready_reg;
    last_bit = (state_reg == SEND) & ena & (count_reg == LAST_BIT);
    // A held nibble starts a frame from IDLE, or chains straight on after the last bit.
    load     = hold_full_reg & ((state_reg == IDLE) | last_bit);
    hold_full_next = accept | (hold_full_reg & ~load);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      count_reg      <= 3'd0;
      shift_reg      <= '0;
      hold_reg       <= 4'd0;
      hold_full_reg  <= 1'b0;
      data_ready_reg <= 1'b0;
    end else begin
      hold_full_reg  <= hold_full_next;
      data_ready_reg <= ~hold_full_next;
      if (accept) begin
        hold_reg <= data_in;
      end
      case (state_reg)
        IDLE: begin
          if (load) begin
            shift_reg <= hamming_encode(hold_reg);
            count_reg <= 3'd0;
            state_reg <= SEND;
          end
        end
        SEND: begin
          if (ena) begin
            if (count_reg == LAST_BIT) begin
              count_reg <= 3'd0;
              if (load) begin
                shift_reg <= hamming_encode(hold_reg);
              end else begin
                shift_reg <= '0;
                state_reg <= IDLE;
              end
            end else begin
              shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
              count_reg <= count_reg + 3'd1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // The shifter is all zeros outside SEND, so encode_out idles low.
  assign encode_out  = shift_reg[FRAME_W-1];
  assign bit_valid   = (state_reg == SEND) & ena;
  assign frame_start = bit_valid & (count_reg == 3'd0);
  assign busy        = (state_reg == SEND) | hold_full_reg;
  assign data_ready  = data_ready_reg;

endmodule

// File: doc/tt_um_hamming_encoder_7_4.md
TT_UM_HAMMING_ENCODER_7_4 -- requirements
Module: tt_um_hamming_encoder_7_4

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port ena, input, 1 bit: bit-rate strobe; one serial bit advances per clk with ena=1.
REQ-004 SHALL have port data_in, input, 4 bits: nibble to encode, data_in[3]=d1 ... data_in[0]=d4.
REQ-005 SHALL have port data_valid, input, 1 bit: data_in is valid this cycle.
REQ-006 SHALL have port data_ready, output, 1 bit: block can accept a nibble this cycle.
REQ-007 SHALL have port encode_out, output, 1 bit: serial codeword bit.
REQ-008 SHALL have port bit_valid, output, 1 bit: encode_out carries a codeword bit this cycle.
REQ-009 SHALL have port frame_start, output, 1 bit: high with bit_valid on the first bit of each codeword.
REQ-010 SHALL have port busy, output, 1 bit: high while in SEND or while the holding register is full.

Function
REQ-011 SHALL compute p1=d1^d2^d4, p2=d1^d3^d4, p3=d2^d3^d4.
REQ-012 SHALL send codeword positions 1..7 in order p1,p2,d1,p3,d2,d3,d4, position 1 first, so a receiver shifting in at the LSB holds p1 at bit 6.
REQ-013 SHALL accept a nibble into a one-entry holding register on any clk with data_valid=1 and data_ready=1, independent of ena.
REQ-014 SHALL drive data_ready = not holding-register-full, as a registered output.
REQ-015 SHALL implement states IDLE and SEND plus a 3-bit bit counter (0..6).
REQ-016 SHALL, in IDLE with the holding register full, load the encoded codeword into the shift register on the next clk, enter SEND with counter=0, and empty the holding register; first bit appears two clks after the accepting edge.
REQ-017 SHALL, in SEND, assert bit_valid=ena, drive encode_out from the current position, and advance the counter only on clk with ena=1.
REQ-018 SHALL, on clk with ena=1 and counter=6 (last bit): if the holding register is full, load it directly (counter=0, no gap bit, frame_start on the next valid bit); otherwise return to IDLE.
REQ-019 SHALL, with ena=0, hold the state, counter and encode_out, with bit_valid=0.
REQ-020 SHALL, when a nibble is accepted on the same clk the holding register is emptied, register the new nibble; data_ready then stays low for one more cycle.
REQ-021 SHALL, in IDLE, drive encode_out=0, bit_valid=0 and frame_start=0.

Reset
REQ-022 SHALL, on clk with rst=1, force IDLE, counter=0, holding register empty, encode_out=0, bit_valid=0, frame_start=0, busy=0, data_ready=0.
REQ-023 SHALL raise data_ready on the first clk after rst falls.
REQ-024 SHALL, when rst is asserted mid-frame, abandon the frame and any held nibble with no further bit_valid.
REQ-025 SHALL give rst priority over ena and data_valid.

Configuration
REQ-026 SHALL, when macro HAMMING_PARITY_EXT_EN is defined, append an 8th bit p0 (even parity over the 7 codeword bits) after position 7, giving 8-bit frames with counter range 0..7.
REQ-027 SHALL, without HAMMING_PARITY_EXT_EN, send 7-bit frames only, with no p0 logic present.

Verification
REQ-028 SHALL cover: reset, then data_in=4'b1011 accepted with ena=1 held high -> serial bits 0,1,1,0,0,1,1 on consecutive cycles, frame_start on the first bit only, then IDLE.
REQ-029 SHALL cover: 4'b0000 then 4'b1111 back-to-back -> 0000000 immediately followed by 1111111 with no gap cycle; data_ready low while the holding register is full.
REQ-030 SHALL cover: ena toggled 1,0,1,0 during a frame of 4'b1011 -> the same 7 bits, each only on ena=1 cycles, with encode_out frozen while ena=0.
REQ-031 SHALL cover: rst=1 at bit 3 of a frame with a nibble held -> the next cycle shows bit_valid=0, busy=0 and data_ready=0, then data_ready=1; no stale bits are sent.
REQ-032 SHALL cover, with HAMMING_PARITY_EXT_EN defined: 4'b1011 -> 01100110; 4'b1111 -> 11111111.
